trisc_ctrl_seq: RTL

Parametrised successor to the TRISC control-unit sequencer: a Moore FSM that fetches, decodes and executes the full 11-instruction TRISC set. Adds:
- configurable memory wait states;
- conditional jumps on datapath flags;
- a HLT state;
- illegal-opcode trapping;
- single-step mode.

It drives the datapath control lines C0–C14 from a decoded 4-bit opcode and sits between the instruction register and the datapath.

---
 rtl/trisc_pkg.sv | 65 ++++++
 rtl/trisc_ctrl_seq_if.sv | 26 ++
 rtl/trisc_wait_cnt.sv | 25 ++
 rtl/trisc_ctrl_seq.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/trisc_pkg.sv
// Shared encodings for the TRISC control sequencer: opcodes, control-line
// bit positions, ALU selects and the 5-bit FSM state encoding.
package trisc_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_STA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_INC = 4'b0110;
    localparam logic [3:0] OP_CLR = 4'b0111;
    localparam logic [3:0] OP_JMP = 4'b1000;
    localparam logic [3:0] OP_JPZ = 4'b1001;
    localparam logic [3:0] OP_JPN = 4'b1010;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int CTL_W = 15;

    localparam int C_CLR_PC     = 0;
    localparam int C_LD_PC      = 1;
    localparam int C_LD_IR      = 2;
    localparam int C_ADR_PC     = 3;
    localparam int C_MEM_RD     = 4;
    localparam int C_MEM_WR     = 5;
    localparam int C_PC_INC     = 7;
    localparam int C_CLR_ACC    = 8;
    localparam int C_INC_ACC    = 9;
    localparam int C_LD_ALU     = 10;
    localparam int C_LD_ACC_MEM = 11;
    localparam int C_ALU_S0     = 12;
    localparam int C_ALU_S1     = 13;
    localparam int C_LD_ACC_ALU = 14;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_XOR = 2'b10;

    typedef enum logic [4:0] {
        S_INIT      = 5'd0,
        S_FETCH     = 5'd1,
        S_FRD       = 5'd2,
        S_DECODE    = 5'd3,
        S_OPADR     = 5'd4,
        S_ORD       = 5'd5,
        S_LDA_WB    = 5'd6,
        S_ALU_LAT   = 5'd7,
        S_ALU_WB    = 5'd8,
        S_STA_WR    = 5'd9,
        S_EX_INC    = 5'd10,
        S_EX_CLR    = 5'd11,
        S_EX_JMP    = 5'd12,
        S_EX_NOP    = 5'd13,
        S_WAIT_STEP = 5'd14,
        S_HALT      = 5'd15
    } state_t;

    function automatic logic [1:0] alu_sel(input logic [3:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_XOR:  return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/trisc_ctrl_seq_if.sv
// Sequencer-facing bundle: instruction/flag/step inputs from the datapath
// side and the control lines plus status flags driven back.
interface trisc_ctrl_seq_if;
    import trisc_pkg::*;

    logic [3:0]       Opcode;
    logic             Zero;
    logic             Neg;
    logic             StepMode;
    logic             Step;
    logic [CTL_W-1:0] Ctl;
    logic             Halted;
    logic             IllegalOp;
    logic             InstrDone;

    modport master (
        output Opcode, Zero, Neg, StepMode, Step,
        input  Ctl, Halted, IllegalOp, InstrDone
    );

    modport slave (
        input  Opcode, Zero, Neg, StepMode, Step,
        output Ctl, Halted, IllegalOp, InstrDone
    );

endinterface

// File: rtl/trisc_wait_cnt.sv
// 4-bit loadable down-counter timing memory accesses; holds at zero.
module trisc_wait_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] count,
    output logic       zero
);

    // Runs on the falling edge alongside the sequencer state register.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/trisc_ctrl_seq.sv
// TRISC control-unit sequencer: Moore FSM with memory wait states, conditional
// jumps, halt, illegal-opcode trap and single-step; all outputs registered.
module trisc_ctrl_seq
    import trisc_pkg::*;
#(
    parameter int MEM_WAIT     = 2,
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic            SysClock,
    input  logic            StartStop,
    trisc_ctrl_seq_if.slave bus
);

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    state_t           state;
    state_t           nxt;
    logic [3:0]       op_q;
    logic             step_q;
    logic             step_edge;
    logic             trap;
    logic             wait_load;
    logic             wait_dec;
    logic [3:0]       cnt;
    logic             cnt_zero;
    logic [3:0]       cnt_after;
    logic             done_nxt;
    logic [CTL_W-1:0] ctl_q;
    logic             halted_q;
    logic             illegal_q;
    logic             done_q;

    function automatic logic [CTL_W-1:0] ctl_of(input state_t s, input logic [1:0] sel);
        logic [CTL_W-1:0] c;
        c = '0;
        case (s)
            S_INIT:   c[C_CLR_PC] = 1'b1;
            S_FETCH:  c[C_ADR_PC] = 1'b1;
            S_FRD: begin
                c[C_ADR_PC] = 1'b1;
                c[C_MEM_RD] = 1'b1;
            end
            S_DECODE: begin
                c[C_LD_IR]  = 1'b1;
                c[C_ADR_PC] = 1'b1;
                c[C_PC_INC] = 1'b1;
            end
            S_ORD:    c[C_MEM_RD]     = 1'b1;
            S_LDA_WB: c[C_LD_ACC_MEM] = 1'b1;
            S_ALU_LAT: begin
                c[C_LD_ALU] = 1'b1;
                c[C_ALU_S0] = sel[0];
                c[C_ALU_S1] = sel[1];
            end
            S_ALU_WB: begin
                c[C_LD_ACC_ALU] = 1'b1;
                c[C_ALU_S0]     = sel[0];
                c[C_ALU_S1]     = sel[1];
            end
            S_STA_WR: c[C_MEM_WR]  = 1'b1;
            S_EX_INC: c[C_INC_ACC] = 1'b1;
            S_EX_CLR: c[C_CLR_ACC] = 1'b1;
            S_EX_JMP: c[C_LD_PC]   = 1'b1;
            S_OPADR, S_EX_NOP, S_WAIT_STEP, S_HALT: ;
            default:  c[C_CLR_PC]  = 1'b1;
        endcase
        return c;
    endfunction

    trisc_wait_cnt u_wait_cnt (
        .clk      (SysClock),
        .rst_n    (StartStop),
        .load     (wait_load),
        .load_val (WAIT_LOAD),
        .dec      (wait_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    always_comb begin
        nxt       = state;
        trap      = 1'b0;
        step_edge = bus.Step & ~step_q;
        case (state)
            S_INIT:  nxt = S_FETCH;
            S_FETCH: nxt = S_FRD;
            S_FRD:   if (cnt_zero) nxt = S_DECODE;
            S_DECODE: begin
                case (bus.Opcode)
                    OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_XOR: nxt = S_OPADR;
                    OP_INC: nxt = S_EX_INC;
                    OP_CLR: nxt = S_EX_CLR;
                    OP_JMP: nxt = S_EX_JMP;
                    OP_JPZ: nxt = bus.Zero ? S_EX_JMP : S_EX_NOP;
                    OP_JPN: nxt = bus.Neg ? S_EX_JMP : S_EX_NOP;
                    OP_HLT: nxt = S_HALT;
                    default: begin
                        if (ILLEGAL_HALT) begin
                            nxt  = S_HALT;
                            trap = 1'b1;
                        end else begin
                            nxt = S_EX_NOP;
                        end
                    end
                endcase
            end
            S_OPADR:   nxt = (op_q == OP_STA) ? S_STA_WR : S_ORD;
            S_ORD:     if (cnt_zero) nxt = (op_q == OP_LDA) ? S_LDA_WB : S_ALU_LAT;
            S_ALU_LAT: nxt = S_ALU_WB;
            S_STA_WR:  if (cnt_zero) nxt = bus.StepMode ? S_WAIT_STEP : S_FETCH;
            S_LDA_WB, S_ALU_WB, S_EX_INC, S_EX_CLR, S_EX_JMP, S_EX_NOP:
                nxt = bus.StepMode ? S_WAIT_STEP : S_FETCH;
            // Edges that arrived earlier are already absorbed into step_q.
            S_WAIT_STEP: if (step_edge || !bus.StepMode) nxt = S_FETCH;
            S_HALT:      nxt = S_HALT;
            default:     nxt = S_INIT;
        endcase
    end

    always_comb begin
        wait_load = (nxt != state) &&
                    ((nxt == S_FRD) || (nxt == S_ORD) || (nxt == S_STA_WR));
        wait_dec  = (state == S_FRD) || (state == S_ORD) || (state == S_STA_WR);
        if (wait_load) begin
            cnt_after = WAIT_LOAD;
        end else if (wait_dec && !cnt_zero) begin
            cnt_after = cnt - 4'd1;
        end else begin
            cnt_after = cnt;
        end
        // The store's last cycle is only known from the counter it will hold.
        case (nxt)
            S_EX_INC, S_EX_CLR, S_EX_JMP, S_EX_NOP, S_LDA_WB, S_ALU_WB: done_nxt = 1'b1;
            S_STA_WR: done_nxt = (cnt_after == 4'd0);
            default:  done_nxt = 1'b0;
        endcase
    end

    always_ff @(negedge SysClock or negedge StartStop) begin
        if (!StartStop) begin
            state     <= S_INIT;
            op_q      <= 4'd0;
            step_q    <= 1'b0;
            ctl_q     <= ctl_of(S_INIT, ALU_ADD);
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state  <= nxt;
            step_q <= bus.Step;
            if (state == S_DECODE) begin
                op_q <= bus.Opcode;
            end
            ctl_q     <= ctl_of(nxt, alu_sel(op_q));
            halted_q  <= (nxt == S_HALT);
            illegal_q <= illegal_q | trap;
            done_q    <= done_nxt;
        end
    end

    assign bus.Ctl       = ctl_q;
    assign bus.Halted    = halted_q;
    assign bus.IllegalOp = illegal_q;
    assign bus.InstrDone = done_q;

endmodule
